// File: rtl/rob_queue.sv
// Reorder buffer: circular queue of in-flight ops with CDB write-back, operand lookup,
// in-order commit to register file / store port / branch predictor, and mispredict flush.
module rob_queue #(
  parameter int ENTRY_W = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int REG_W   = 5,
  parameter int DEPTH   = 1 << ENTRY_W,
  parameter int BUS_W   = 2 + ADDR_W + DATA_W + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rob_write,
  input  logic [BUS_W-1:0]    rob_bus,
  output logic [ENTRY_W-1:0]  rob_rd_lock,
  output logic                rob_full,
  input  logic                rob_check_rs1,
  input  logic                rob_check_rs2,
  input  logic [ENTRY_W-1:0]  rob_value_entry1,
  input  logic [ENTRY_W-1:0]  rob_value_entry2,
  output logic                rob_value_enable1,
  output logic                rob_value_enable2,
  output logic [DATA_W-1:0]   rob_value1,
  output logic [DATA_W-1:0]   rob_value2,
  input  logic                cdb_valid,
  input  logic [ENTRY_W-1:0]  cdb_entry,
  input  logic [DATA_W-1:0]   cdb_data,
  output logic                reg_commit,
  output logic [REG_W-1:0]    reg_commit_name,
  output logic [ENTRY_W-1:0]  reg_commit_entry,
  output logic [DATA_W-1:0]   reg_commit_data,
  output logic                st_commit,
  output logic [ADDR_W-1:0]   st_addr,
  output logic [DATA_W-1:0]   st_data,
  output logic                bp_update,
  output logic [DATA_W-3:0]   bp_addr,
  output logic                bp_taken,
  output logic                flush,
  output logic [ADDR_W-1:0]   flush_pc
);

  typedef enum logic [1:0] {
    ROB_NONE   = 2'd0,
    ROB_BRANCH = 2'd1,
    ROB_STORE  = 2'd2,
    ROB_NORMAL = 2'd3
  } rob_type_e;

  localparam logic [ENTRY_W:0] FULL_CNT = {1'b1, {ENTRY_W{1'b0}}};

  logic [DEPTH-1:0]   valid_q;
  logic [DEPTH-1:0]   ready_q;
  rob_type_e          type_q [DEPTH];
  logic [ADDR_W-1:0]  addr_q [DEPTH];
  logic [DATA_W-1:0]  data_q [DEPTH];
  logic [ENTRY_W-1:0] head_q, tail_q;
  logic [ENTRY_W:0]   count_q;

  logic               reg_commit_q, st_commit_q, bp_update_q, bp_taken_q, flush_q;
  logic [REG_W-1:0]   reg_commit_name_q;
  logic [ENTRY_W-1:0] reg_commit_entry_q;
  logic [DATA_W-1:0]  reg_commit_data_q, st_data_q;
  logic [ADDR_W-1:0]  st_addr_q, flush_pc_q;
  logic [DATA_W-3:0]  bp_addr_q;

  rob_type_e          bus_type;
  logic [ADDR_W-1:0]  bus_addr;
  logic [DATA_W-1:0]  bus_data;
  logic               bus_ready;

  rob_type_e          head_type;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;
  logic               commit_now, flush_next, alloc;
  logic               hit1, hit2;

  assign bus_type  = rob_type_e'(rob_bus[BUS_W-1 -: 2]);
  assign bus_addr  = rob_bus[BUS_W-3 -: ADDR_W];
  assign bus_data  = rob_bus[DATA_W:1];
  assign bus_ready = rob_bus[0];

  assign head_type  = type_q[head_q];
  assign head_addr  = addr_q[head_q];
  assign head_data  = data_q[head_q];
  assign commit_now = valid_q[head_q] && ready_q[head_q];
  // Mispredict: predicted (bit 1) disagrees with resolved (bit 0).
  assign flush_next = commit_now && (head_type == ROB_BRANCH) && (head_data[1] != head_data[0]);

  assign rob_full    = (count_q == FULL_CNT);
  assign rob_rd_lock = tail_q;
  assign alloc       = rob_write && !rob_full && !flush_next;

  always_comb begin
    hit1 = cdb_valid && (cdb_entry == rob_value_entry1);
    hit2 = cdb_valid && (cdb_entry == rob_value_entry2);
    rob_value_enable1 = rob_check_rs1 && valid_q[rob_value_entry1] && (ready_q[rob_value_entry1] || hit1);
    rob_value_enable2 = rob_check_rs2 && valid_q[rob_value_entry2] && (ready_q[rob_value_entry2] || hit2);
    rob_value1 = '0;
    rob_value2 = '0;
    if (rob_value_enable1) rob_value1 = hit1 ? cdb_data : data_q[rob_value_entry1];
    if (rob_value_enable2) rob_value2 = hit2 ? cdb_data : data_q[rob_value_entry2];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      ready_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        type_q[i] <= ROB_NONE;
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      reg_commit_q       <= 1'b0;
      reg_commit_name_q  <= '0;
      reg_commit_entry_q <= '0;
      reg_commit_data_q  <= '0;
      st_commit_q        <= 1'b0;
      st_addr_q          <= '0;
      st_data_q          <= '0;
      bp_update_q        <= 1'b0;
      bp_addr_q          <= '0;
      bp_taken_q         <= 1'b0;
      flush_q            <= 1'b0;
      flush_pc_q         <= '0;
    end else begin
      reg_commit_q       <= 1'b0;
      reg_commit_name_q  <= '0;
      reg_commit_entry_q <= '0;
      reg_commit_data_q  <= '0;
      st_commit_q        <= 1'b0;
      st_addr_q          <= '0;
      st_data_q          <= '0;
      bp_update_q        <= 1'b0;
      bp_addr_q          <= '0;
      bp_taken_q         <= 1'b0;
      flush_q            <= 1'b0;
      flush_pc_q         <= '0;

      if (flush_next) begin
        valid_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (cdb_valid && valid_q[cdb_entry]) begin
          ready_q[cdb_entry] <= 1'b1;
          if (type_q[cdb_entry] == ROB_BRANCH) data_q[cdb_entry][0] <= cdb_data[0];
          else                                 data_q[cdb_entry]    <= cdb_data;
        end
        // Tail slot is always invalid when allocating, so it never collides with CDB or commit.
        if (alloc) begin
          valid_q[tail_q] <= 1'b1;
          ready_q[tail_q] <= bus_ready;
          type_q[tail_q]  <= bus_type;
          addr_q[tail_q]  <= bus_addr;
          data_q[tail_q]  <= bus_data;
          tail_q          <= tail_q + 1'b1;
        end
        if (commit_now) begin
          valid_q[head_q] <= 1'b0;
          head_q          <= head_q + 1'b1;
        end
        if (alloc && !commit_now)      count_q <= count_q + 1'b1;
        else if (!alloc && commit_now) count_q <= count_q - 1'b1;
      end

      if (commit_now) begin
        unique case (head_type)
          ROB_NORMAL: begin
            reg_commit_q       <= 1'b1;
            reg_commit_name_q  <= head_addr[REG_W-1:0];
            reg_commit_entry_q <= head_q;
            reg_commit_data_q  <= head_data;
          end
          ROB_STORE: begin
            st_commit_q <= 1'b1;
            st_addr_q   <= head_addr;
            st_data_q   <= head_data;
          end
          ROB_BRANCH: begin
            bp_update_q <= 1'b1;
            bp_addr_q   <= head_data[DATA_W-1:2];
            bp_taken_q  <= head_data[0];
            flush_q     <= flush_next;
            flush_pc_q  <= flush_next ? head_addr : '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign reg_commit       = reg_commit_q;
  assign reg_commit_name  = reg_commit_name_q;
  assign reg_commit_entry = reg_commit_entry_q;
  assign reg_commit_data  = reg_commit_data_q;
  assign st_commit        = st_commit_q;
  assign st_addr          = st_addr_q;
  assign st_data          = st_data_q;
  assign bp_update        = bp_update_q;
  assign bp_addr          = bp_addr_q;
  assign bp_taken         = bp_taken_q;
  assign flush            = flush_q;
  assign flush_pc         = flush_pc_q;

endmodule

// File: tb/tb_rob_queue.sv
// Directed bench for rob_queue: commit paths, full/drop, CDB bypass, flush, wrap, reset.
module tb_rob_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rob_write = 1'b0;
  logic [66:0] rob_bus = '0;
  logic [2:0]  rob_rd_lock;
  logic        rob_full;
  logic        rob_check_rs1 = 1'b0, rob_check_rs2 = 1'b0;
  logic [2:0]  rob_value_entry1 = '0, rob_value_entry2 = '0;
  logic        rob_value_enable1, rob_value_enable2;
  logic [31:0] rob_value1, rob_value2;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_entry = '0;
  logic [31:0] cdb_data = '0;
  logic        reg_commit;
  logic [4:0]  reg_commit_name;
  logic [2:0]  reg_commit_entry;
  logic [31:0] reg_commit_data;
  logic        st_commit;
  logic [31:0] st_addr, st_data;
  logic        bp_update;
  logic [29:0] bp_addr;
  logic        bp_taken;
  logic        flush;
  logic [31:0] flush_pc;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  rob_queue #(.ENTRY_W(3), .DATA_W(32), .ADDR_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .rob_write(rob_write), .rob_bus(rob_bus),
    .rob_rd_lock(rob_rd_lock), .rob_full(rob_full),
    .rob_check_rs1(rob_check_rs1), .rob_check_rs2(rob_check_rs2),
    .rob_value_entry1(rob_value_entry1), .rob_value_entry2(rob_value_entry2),
    .rob_value_enable1(rob_value_enable1), .rob_value_enable2(rob_value_enable2),
    .rob_value1(rob_value1), .rob_value2(rob_value2),
    .cdb_valid(cdb_valid), .cdb_entry(cdb_entry), .cdb_data(cdb_data),
    .reg_commit(reg_commit), .reg_commit_name(reg_commit_name),
    .reg_commit_entry(reg_commit_entry), .reg_commit_data(reg_commit_data),
    .st_commit(st_commit), .st_addr(st_addr), .st_data(st_data),
    .bp_update(bp_update), .bp_addr(bp_addr), .bp_taken(bp_taken),
    .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [66:0] mk(input logic [1:0] t, input logic [31:0] a,
                                     input logic [31:0] d, input logic r);
    return {t, a, d, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_rd_lock", 64'(rob_rd_lock), 64'd0);
    chk("rst_full", 64'(rob_full), 64'd0);
    chk("rst_reg_commit", 64'(reg_commit), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    rst = 1'b1;
    step();

    // Single ready Normal_Op: allocate at entry 0, commit one edge later
    rob_write = 1'b1;
    rob_bus = mk(2'd3, 32'd5, 32'h1234, 1'b1);
    step();
    rob_write = 1'b0;
    chk("n1_rd_lock", 64'(rob_rd_lock), 64'd1);
    chk("n1_no_early_commit", 64'(reg_commit), 64'd0);
    step();
    chk("n1_reg_commit", 64'(reg_commit), 64'd1);
    chk("n1_name", 64'(reg_commit_name), 64'd5);
    chk("n1_entry", 64'(reg_commit_entry), 64'd0);
    chk("n1_data", 64'(reg_commit_data), 64'h1234);
    chk("n1_no_store", 64'(st_commit), 64'd0);
    step();
    chk("n1_pulse_end", 64'(reg_commit), 64'd0);

    // Fill entries 1..7,0 with unready ops
    for (int i = 0; i < 8; i++) begin
      rob_write = 1'b1;
      rob_bus = mk(2'd3, 32'((1 + i) % 8), 32'(((1 + i) % 8) * 16), 1'b0);
      step();
    end
    chk("fill_full", 64'(rob_full), 64'd1);
    chk("fill_rd_lock", 64'(rob_rd_lock), 64'd1);
    rob_bus = mk(2'd3, 32'd9, 32'hdead, 1'b1);
    step();
    rob_write = 1'b0;
    chk("drop_full", 64'(rob_full), 64'd1);
    chk("drop_rd_lock", 64'(rob_rd_lock), 64'd1);
    cdb_valid = 1'b1; cdb_entry = 3'd1; cdb_data = 32'd7;
    step();
    cdb_valid = 1'b0;
    chk("drop_no_commit", 64'(reg_commit), 64'd0);
    chk("cdb_still_full", 64'(rob_full), 64'd1);
    step();
    chk("head_commit", 64'(reg_commit), 64'd1);
    chk("head_name", 64'(reg_commit_name), 64'd1);
    chk("head_entry", 64'(reg_commit_entry), 64'd1);
    chk("head_data", 64'(reg_commit_data), 64'd7);
    chk("full_drops", 64'(rob_full), 64'd0);

    // Same-cycle CDB bypass on lookup port 1; port 2 looks at an unready entry
    cdb_valid = 1'b1; cdb_entry = 3'd3; cdb_data = 32'h55;
    rob_check_rs1 = 1'b1; rob_value_entry1 = 3'd3;
    rob_check_rs2 = 1'b1; rob_value_entry2 = 3'd4;
    #1;
    chk("byp_en1", 64'(rob_value_enable1), 64'd1);
    chk("byp_val1", 64'(rob_value1), 64'h55);
    chk("byp_en2", 64'(rob_value_enable2), 64'd0);
    chk("byp_val2", 64'(rob_value2), 64'd0);
    step();
    cdb_valid = 1'b0;
    #1;
    chk("stored_en1", 64'(rob_value_enable1), 64'd1);
    chk("stored_val1", 64'(rob_value1), 64'h55);
    rob_check_rs1 = 1'b0; rob_check_rs2 = 1'b0;
    #1;
    chk("nocheck_en1", 64'(rob_value_enable1), 64'd0);
    chk("nocheck_val1", 64'(rob_value1), 64'd0);

    // Head ready and committing, then reset mid-operation with entries still pending
    cdb_valid = 1'b1; cdb_entry = 3'd2; cdb_data = 32'h22;
    step();
    cdb_valid = 1'b0;
    step();
    chk("pre_rst_commit", 64'(reg_commit), 64'd1);
    chk("pre_rst_data", 64'(reg_commit_data), 64'h22);
    rst = 1'b0;
    #1;
    chk("async_rst_commit", 64'(reg_commit), 64'd0);
    chk("async_rst_data", 64'(reg_commit_data), 64'd0);
    chk("async_rst_rd_lock", 64'(rob_rd_lock), 64'd0);
    step();
    rst = 1'b1;
    step();
    chk("post_rst_commit_a", 64'(reg_commit), 64'd0);
    step();
    chk("post_rst_commit_b", 64'(reg_commit), 64'd0);
    chk("post_rst_rd_lock", 64'(rob_rd_lock), 64'd0);

    // Mispredicted branch (pred=1, actual=0) followed by two ready ops
    rob_write = 1'b1;
    rob_bus = mk(2'd1, 32'h100, {30'h280, 2'b10}, 1'b0);
    step();
    rob_bus = mk(2'd3, 32'd7, 32'd70, 1'b1);
    step();
    rob_bus = mk(2'd3, 32'd8, 32'd80, 1'b1);
    step();
    rob_write = 1'b0;
    chk("br_rd_lock", 64'(rob_rd_lock), 64'd3);
    cdb_valid = 1'b1; cdb_entry = 3'd0; cdb_data = 32'd0;
    step();
    cdb_valid = 1'b0;
    rob_write = 1'b1;
    rob_bus = mk(2'd3, 32'd9, 32'd9, 1'b1);
    step();
    rob_write = 1'b0;
    chk("mp_bp_update", 64'(bp_update), 64'd1);
    chk("mp_bp_addr", 64'(bp_addr), 64'h280);
    chk("mp_bp_taken", 64'(bp_taken), 64'd0);
    chk("mp_flush", 64'(flush), 64'd1);
    chk("mp_flush_pc", 64'(flush_pc), 64'h100);
    chk("mp_rd_lock", 64'(rob_rd_lock), 64'd0);
    chk("mp_full", 64'(rob_full), 64'd0);
    step();
    chk("mp_flush_end", 64'(flush), 64'd0);
    chk("mp_no_stale_commit", 64'(reg_commit), 64'd0);
    chk("mp_rd_lock_hold", 64'(rob_rd_lock), 64'd0);

    // Stream 7 ready ops then a correctly predicted branch at entry 7, then wrap to entry 0
    for (int i = 0; i < 7; i++) begin
      rob_write = 1'b1;
      rob_bus = mk(2'd3, 32'(i + 10), 32'(i), 1'b1);
      step();
    end
    rob_bus = mk(2'd1, 32'h200, {30'h3, 2'b11}, 1'b1);
    step();
    chk("wrap_commit6", 64'(reg_commit_entry), 64'd6);
    chk("wrap_name6", 64'(reg_commit_name), 64'd16);
    chk("wrap_rd_lock", 64'(rob_rd_lock), 64'd0);
    rob_bus = mk(2'd3, 32'd31, 32'hABCD, 1'b1);
    step();
    rob_write = 1'b0;
    chk("ok_bp_update", 64'(bp_update), 64'd1);
    chk("ok_bp_taken", 64'(bp_taken), 64'd1);
    chk("ok_bp_addr", 64'(bp_addr), 64'd3);
    chk("ok_flush", 64'(flush), 64'd0);
    chk("ok_no_reg", 64'(reg_commit), 64'd0);
    step();
    chk("wrap_reg_commit", 64'(reg_commit), 64'd1);
    chk("wrap_entry0", 64'(reg_commit_entry), 64'd0);
    chk("wrap_name31", 64'(reg_commit_name), 64'd31);
    chk("wrap_bp_end", 64'(bp_update), 64'd0);

    // Store commit from entry 1
    rob_write = 1'b1;
    rob_bus = mk(2'd2, 32'hCAFE0000, 32'h77, 1'b1);
    step();
    rob_write = 1'b0;
    step();
    chk("st_commit", 64'(st_commit), 64'd1);
    chk("st_addr", 64'(st_addr), 64'hCAFE0000);
    chk("st_data", 64'(st_data), 64'h77);
    chk("st_no_reg", 64'(reg_commit), 64'd0);

    // CDB hit on an invalid entry gives no lookup result
    cdb_valid = 1'b1; cdb_entry = 3'd5; cdb_data = 32'h1;
    rob_check_rs1 = 1'b1; rob_value_entry1 = 3'd5;
    #1;
    chk("inv_en1", 64'(rob_value_enable1), 64'd0);
    step();
    cdb_valid = 1'b0;
    #1;
    chk("inv_stays", 64'(rob_value_enable1), 64'd0);
    rob_check_rs1 = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
